// File: rtl/mem_rr_arbiter_if.sv
// Bus bundle for mem_rr_arbiter: N picorv32 native-interface core ports plus one downstream bus.
// master = arbiter view, slave = cores/memory view.
interface mem_rr_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int ID_BITS = ($clog2(N_CORES) > 0 ? $clog2(N_CORES) : 1)
);
    logic [N_CORES-1:0]    req_valid;
    logic [32*N_CORES-1:0] req_addr;
    logic [32*N_CORES-1:0] req_wdata;
    logic [4*N_CORES-1:0]  req_wstrb;
    logic [N_CORES-1:0]    req_ready;
    logic [32*N_CORES-1:0] req_rdata;
    logic                  mem_valid;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;
    logic [ID_BITS-1:0]    grant_id;
    logic                  timeout_err;

    modport master (
        input  req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
        output req_ready, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb,
               grant_id, timeout_err
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
        input  req_ready, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb,
               grant_id, timeout_err
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory bus between N cores, one transaction at a time.
// Optional busy watchdog enabled by defining MEM_RR_ARBITER_WATCHDOG_EN.
module mem_rr_arbiter #(
    parameter int N_CORES = 4,
    parameter int ID_BITS = ($clog2(N_CORES) > 0 ? $clog2(N_CORES) : 1),
    parameter int TIMEOUT = 255
) (
    input logic             clk,
    input logic             resetn,
    mem_rr_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state, state_nxt;
    logic [ID_BITS-1:0]    ptr, grant, winner, cand;
    logic                  found;
    logic                  complete, timed_out, to_flag;
    logic [31:0]           addr_q, wdata_q;
    logic [3:0]            wstrb_q;
    logic [32*N_CORES-1:0] rdata_q;

    // First requester after ptr, wrapping modulo N_CORES
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= N_CORES; i++) begin
            cand = ID_BITS'((32'(ptr) + i) % N_CORES);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

`ifdef MEM_RR_ARBITER_WATCHDOG_EN
    localparam int WD_BITS = (TIMEOUT < 256) ? 8 : 16;
    logic [WD_BITS-1:0] wd_cnt;

    // Fires on the BUSY cycle whose count would reach TIMEOUT; mem_ready wins a tie
    assign timed_out = (state == BUSY) && !bus.mem_ready && (wd_cnt == WD_BITS'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (state == IDLE) begin
            wd_cnt  <= '0;
        end else if (state == BUSY) begin
            to_flag <= timed_out;
            if (!bus.mem_ready)
                wd_cnt <= wd_cnt + WD_BITS'(1);
        end
    end
`else
    assign timed_out = 1'b0;
    assign to_flag   = 1'b0;
`endif

    assign complete = bus.mem_ready || timed_out;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = BUSY;
            BUSY:    if (complete) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_valid   = (state == BUSY);
        bus.req_ready   = '0;
        bus.timeout_err = 1'b0;
        if (state == RESP) begin
            bus.req_ready[grant] = 1'b1;
            bus.timeout_err      = to_flag;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr     <= ID_BITS'(N_CORES - 1);
            grant   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant   <= winner;
                    addr_q  <= bus.req_addr[32*winner +: 32];
                    wdata_q <= bus.req_wdata[32*winner +: 32];
                    wstrb_q <= bus.req_wstrb[4*winner +: 4];
                end
                BUSY: if (complete) begin
                    rdata_q[32*grant +: 32] <= bus.mem_ready ? bus.mem_rdata : '1;
                    ptr <= grant;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.req_rdata = rdata_q;
    assign bus.grant_id  = grant;
endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one native-interface memory/IO bus (RAM, LED, UART decode) between N picorv32 cores.
- Each core side carries the picorv32 native handshake (valid/ready, addr, wdata, wstrb, rdata).
- The downstream side drives a single-master bus that the existing address decode consumes unchanged.
- One transaction is outstanding at a time. Per-core read data is latched, which is compatible with LATCHED_MEM_RDATA=1.

Parameters:
- N_CORES, 4, number of requesting cores (1..8).
- ID_BITS, ($clog2(N_CORES) > 0 ? $clog2(N_CORES) : 1), width of grant_id.
- TIMEOUT, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  N_CORES  per-core mem_valid
- req_addr  in  32*N_CORES  per-core address, core k at [32k+31:32k]
- req_wdata  in  32*N_CORES  per-core write data
- req_wstrb  in  4*N_CORES  per-core byte strobes; 0 = read
- req_ready  out  N_CORES  per-core completion pulse
- req_rdata  out  32*N_CORES  per-core latched read data
- mem_valid  out  1  downstream request
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_wstrb  out  4  downstream strobes
- mem_ready  in  1  downstream completion
- mem_rdata  in  32  downstream read data
- grant_id  out  ID_BITS  index of the core currently or last granted
- timeout_err  out  1  one-cycle watchdog pulse

Behaviour:
- Reset (asynchronous, resetn=0):
  - State=IDLE; mem_valid, req_ready, timeout_err = 0.
  - mem_addr, mem_wdata, mem_wstrb, req_rdata, grant_id = 0.
  - Priority pointer ptr = N_CORES-1, so core 0 wins first.
  - Asserting reset mid-transaction aborts it with no req_ready pulse.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning ptr+1, ptr+2, ... modulo N_CORES.
  - Register that core's addr/wdata/wstrb into mem_*; set grant_id to the winner; go to BUSY.
  - If no req_valid is set, stay in IDLE. mem_ready is ignored in IDLE.
- BUSY:
  - mem_valid=1. mem_addr, mem_wdata, mem_wstrb are held stable.
  - On mem_ready=1:
    - mem_valid<=0.
    - req_ready[grant_id]<=1.
    - The req_rdata slice of grant_id <= mem_rdata; this is captured for writes too.
    - ptr<=grant_id; go to RESP.
- RESP:
  - req_ready is high for exactly this cycle; then go to IDLE.
  - The core drops valid on the following cycle, so it is not re-granted.
- Latency:
  - Request seen in IDLE at cycle t gives mem_valid at t+1.
  - mem_ready at cycle t+k (k≥1) gives req_ready at t+k+1.
  - Minimum 3 cycles per transaction; back-to-back grants to different cores are 3 cycles apart.
- Fairness: ptr advances only on completion, so a core waits at most N_CORES-1 transactions.
- req_rdata slices of non-granted cores never change.
- req_valid dropped by the granted core during BUSY: the transaction still completes. req_valid toggling on non-granted cores has no effect.
- N_CORES=1: the arbiter degenerates to a pass-through register stage; grant_id stays 0.

Optional Feature:
- Macro: MEM_RR_ARBITER_WATCHDOG_EN.
- Defined:
  - An 8-to-16 bit counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT, the transaction is forced complete: mem_valid<=0, req_ready[grant_id]<=1, rdata slice <= 32'hFFFF_FFFF, timeout_err<=1 for one cycle, ptr<=grant_id, go to RESP.
  - mem_ready on the same cycle as the timeout takes precedence: normal completion, no error.
- Undefined: no counter is built, timeout_err is tied 0, and BUSY waits indefinitely.

Test Plan:
- Reset, then core 0 reads addr 0x10 with mem_ready returned 1 cycle after mem_valid and mem_rdata=0xDEADBEEF -> req_ready[0] pulses 1 cycle; slice 0 = 0xDEADBEEF; grant_id=0; other slices stay 0.
- All 4 cores hold req_valid continuously with mem_ready immediate -> grant order 0,1,2,3,0,...; each grant exactly 3 cycles apart.
- Core 2 writes 0x1000_0000 with wdata=0x55, wstrb=4'b0001 while core 1 raises valid mid-transaction -> mem_addr/mem_wdata/mem_wstrb stable through BUSY; core 1 granted next.
- Assert resetn=0 during BUSY with mem_ready held low -> mem_valid falls immediately (asynchronously); no req_ready; after release, core 0 is served first.
- With MEM_RR_ARBITER_WATCHDOG_EN defined and TIMEOUT=8, mem_ready never asserted -> after 8 BUSY cycles, req_ready and timeout_err pulse and slice = 0xFFFFFFFF. Without the macro, the bench sees mem_valid held for 100 cycles.
